// File: rtl/output_uart_tx_pkg.sv
// Shared definitions for the CPU output-port UART: ASCII constants,
// serializer state encoding and nibble-to-hex conversion.
package output_uart_tx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_0 + {4'h0, n};
    else           return ASCII_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/output_uart_tx_byte.sv
// 8N1 byte serializer. Accepts a new byte on the Done cycle so consecutive
// characters leave the line with no idle gap between stop and start bits.
module uart_tx_byte
  import output_uart_tx_pkg::*;
#(
  parameter int Divisor = 138
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Data,
  output logic       Tx,
  output logic       Busy,
  output logic       Done
);

  localparam int CntW = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(Divisor - 1);

  tx_state_t       state, state_next;
  logic [CntW-1:0] baud_cnt, baud_next;
  logic [2:0]      bit_cnt, bit_next;
  logic [7:0]      shreg, shreg_next;
  logic            tx_next;
  logic            bit_end;

  assign bit_end = (baud_cnt == BaudLast);
  assign Busy    = (state != ST_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      Tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
      Tx       <= tx_next;
    end
  end

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + 1'b1;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    Done       = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_next = '0;
        if (Start) begin
          state_next = ST_START;
          shreg_next = Data;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          baud_next  = '0;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_cnt == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_next   = bit_cnt + 1'b1;
            shreg_next = {1'b0, shreg[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          Done      = 1'b1;
          baud_next = '0;
          bit_next  = '0;
          if (Start) begin
            state_next = ST_START;
            shreg_next = Data;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Tx is registered from the next state so the pin never glitches on decode.
    tx_next = 1'b1;
    if (state_next == ST_START)     tx_next = 1'b0;
    else if (state_next == ST_DATA) tx_next = shreg_next[0];
  end

endmodule

// File: rtl/output_uart_tx.sv
// Sends each CPU output-register load as upper-case hex + CR LF over UART 8N1,
// with a one-deep hold buffer and a sticky overrun flag for dropped loads.
module output_uart_tx
  import output_uart_tx_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int ClkFreq   = 16_000_000,
  parameter int BaudRate  = 115200
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Output_Ld,
  input  logic [DataWidth-1:0] OutReg,
  input  logic                 Overrun_Clr,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 Overrun
);

  localparam int Divisor = ClkFreq / BaudRate;
  localparam int Digits  = DataWidth / 4;
  localparam int IdxW    = $clog2(Digits + 2);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Digits + 1);

  logic                 ld_s1, ld_s2, ld_s3;
  logic                 ev;
  logic [DataWidth-1:0] active, hold;
  logic                 hold_valid;
  logic [IdxW-1:0]      char_idx, idx_next;
  logic                 byte_start, byte_busy, byte_done;
  logic [7:0]           byte_data;
  logic                 msg_end;
  logic                 load_active, hold_load, hold_clear, drop;
  logic [DataWidth-1:0] new_active;

  function automatic logic [7:0] msg_char(input logic [DataWidth-1:0] val,
                                          input logic [IdxW-1:0]      idx);
    logic [DataWidth-1:0] sh;
    if (int'(idx) < Digits) begin
      sh = val >> (4 * (Digits - 1 - int'(idx)));
      return hex_ascii(sh[3:0]);
    end else if (int'(idx) == Digits) begin
      return ASCII_CR;
    end else begin
      return ASCII_LF;
    end
  endfunction

  // Load strobe crosses from the CPU clock; a rising edge of the synchronized
  // level is one event no matter how long Output_Ld stays high.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ld_s1 <= 1'b0;
      ld_s2 <= 1'b0;
      ld_s3 <= 1'b0;
    end else begin
      ld_s1 <= Output_Ld;
      ld_s2 <= ld_s1;
      ld_s3 <= ld_s2;
    end
  end

  assign ev      = ld_s2 & ~ld_s3;
  assign msg_end = byte_done && (char_idx == LastIdx);
  assign Busy    = byte_busy;

  always_comb begin
    byte_start  = 1'b0;
    byte_data   = 8'h00;
    load_active = 1'b0;
    new_active  = OutReg;
    idx_next    = char_idx;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;
    drop        = 1'b0;

    if (!byte_busy) begin
      load_active = ev;
    end else if (byte_done && !msg_end) begin
      idx_next   = char_idx + 1'b1;
      byte_start = 1'b1;
      byte_data  = msg_char(active, idx_next);
    end else if (msg_end) begin
      idx_next = '0;
      if (hold_valid) begin
        // Held message goes out next; a coincident load takes its place.
        load_active = 1'b1;
        new_active  = hold;
        hold_load   = ev;
        hold_clear  = !ev;
      end else begin
        load_active = ev;
      end
    end

    if (byte_busy && ev && !msg_end) begin
      if (hold_valid) drop      = 1'b1;
      else            hold_load = 1'b1;
    end

    if (load_active) begin
      idx_next   = '0;
      byte_start = 1'b1;
      byte_data  = msg_char(new_active, '0);
    end
  end

  // NOTE: the data registers are reset along with the control bits; they are
  // few flops, and a known value keeps the first message deterministic.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      active     <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      char_idx   <= '0;
      Overrun    <= 1'b0;
    end else begin
      char_idx <= idx_next;
      if (load_active) active <= new_active;
      if (hold_load) begin
        hold       <= OutReg;
        hold_valid <= 1'b1;
      end else if (hold_clear) begin
        hold_valid <= 1'b0;
      end
      if (drop)             Overrun <= 1'b1;
      else if (Overrun_Clr) Overrun <= 1'b0;
    end
  end

  uart_tx_byte #(
    .Divisor (Divisor)
  ) u_byte (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (byte_start),
    .Data  (byte_data),
    .Tx    (Tx),
    .Busy  (byte_busy),
    .Done  (byte_done)
  );

endmodule

// File: tb/tb_output_uart_tx.sv
// Bench for output_uart_tx: directed scenarios plus random loads, every cycle
// compared against a message-timeline reference model.
module tb_output_uart_tx;

  localparam int D   = 10;
  localparam int DIG = 4;
  localparam int M   = (DIG + 2) * 10 * D;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld;
  logic        clr;
  logic [15:0] outreg;
  logic        tx, busy, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: each accepted message is a start cycle plus a value.
  int          m_start[$];
  logic [15:0] m_val[$];
  bit          m_ovr;
  bit          m_h1, m_h2, m_h3;

  always #5 clk = ~clk;

  output_uart_tx #(
    .DataWidth (16),
    .ClkFreq   (100),
    .BaudRate  (10)
  ) dut (
    .Clk         (clk),
    .Reset       (rst),
    .Output_Ld   (ld),
    .OutReg      (outreg),
    .Overrun_Clr (clr),
    .Tx          (tx),
    .Busy        (busy),
    .Overrun     (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [15:0] v, input int i);
    int n;
    if (i < DIG) begin
      n = (v >> (4 * (DIG - 1 - i))) & 16'hF;
      return (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
    end
    return (i == DIG) ? 8'h0D : 8'h0A;
  endfunction

  function automatic bit exp_tx(input int c);
    int o, bpos;
    logic [7:0] ch;
    foreach (m_start[i]) begin
      if (c >= m_start[i] && c < m_start[i] + M) begin
        o    = c - m_start[i];
        bpos = (o % (10 * D)) / D;
        if (bpos == 0) return 1'b0;
        if (bpos == 9) return 1'b1;
        ch = exp_char(m_val[i], o / (10 * D));
        return ch[bpos-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic bit exp_busy(input int c);
    foreach (m_start[i])
      if (c >= m_start[i] && c < m_start[i] + M) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_active(input int c);
    foreach (m_start[i])
      if (c < m_start[i] + M) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_clear();
    m_start.delete();
    m_val.delete();
    m_ovr = 1'b0;
    m_h1 = 1'b0; m_h2 = 1'b0; m_h3 = 1'b0;
  endfunction

  // Load event seen on cycle t with value v; returns 1 if the load is dropped.
  function automatic bit model_event(input int t, input logic [15:0] v);
    int inf = -1, npend = 0, pend_start = 0;
    foreach (m_start[i]) begin
      if (m_start[i] <= t && t <= m_start[i] + M - 1) inf = i;
      if (m_start[i] > t) begin npend++; pend_start = m_start[i]; end
    end
    if (npend == 0) begin
      m_start.push_back((inf >= 0) ? m_start[inf] + M : t + 1);
      m_val.push_back(v);
      return 1'b0;
    end
    if (inf >= 0 && t == m_start[inf] + M - 1) begin
      m_start.push_back(pend_start + M);
      m_val.push_back(v);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_edge();
    bit dropped = 1'b0;
    if (rst) begin
      model_clear();
      return;
    end
    if (m_h2 && !m_h3) dropped = model_event(cyc - 1, outreg);
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = ld;
    if (dropped)  m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    while (m_start.size() > 0 && m_start[0] + M < cyc - 4) begin
      void'(m_start.pop_front());
      void'(m_val.pop_front());
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check("tx", tx, exp_tx(cyc));
    check("busy", busy, exp_busy(cyc));
    check("overrun", overrun, m_ovr);
  endtask

  task automatic pulse(input logic [15:0] v, input int width);
    outreg = v;
    ld = 1'b1;
    repeat (width) tick();
    ld = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (model_active(cyc + 1) && guard < 4 * M) begin
      tick();
      guard++;
    end
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    model_clear();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, gap, r;
    rst = 1'b1; ld = 1'b0; clr = 1'b0; outreg = '0;
    model_clear();
    #1;
    check("init_tx", tx, 1'b1);
    check("init_busy", busy, 1'b0);
    check("init_overrun", overrun, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    // 1A2F -> "1A2F\r\n", 600 cycles, then idle
    pulse(16'h1A2F, 2);
    wait_idle();
    check("t2_busy_after", busy, 1'b0);

    // Reset mid-frame, then silence
    pulse(16'h5A5A, 3);
    repeat (150) tick();
    do_reset();
    repeat (200) tick();
    check("t1_quiet", busy, 1'b0);

    // Back-to-back messages without overrun
    pulse(16'h0000, 2);
    repeat (96) tick();
    pulse(16'hFFFF, 2);
    wait_idle();
    check("t3_overrun", overrun, 1'b0);

    // Three loads inside one message: third dropped
    pulse(16'h0001, 2);
    pulse(16'h0002, 2);
    pulse(16'h0003, 2);
    check("t4_overrun_set", overrun, 1'b1);
    wait_idle();
    check("t4_overrun_sticky", overrun, 1'b1);

    // Clear, then one long load level = one message
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("t5_overrun_clr", overrun, 1'b0);
    pulse(16'hBEEF, 50);
    wait_idle();

    // Load event on the exact completion cycle while hold is full
    k0 = cyc;
    pulse(16'h1234, 2);
    pulse(16'hC0DE, 2);
    while (cyc < k0 + M) tick();
    pulse(16'h9876, 2);
    check("t6_overrun", overrun, 1'b0);
    wait_idle();
    check("t6_overrun_end", overrun, 1'b0);
    check("t6_busy_end", busy, 1'b0);

    // Random loads, clears and resets
    for (int it = 0; it < 30; it++) begin
      gap = $urandom_range(0, 700);
      repeat (gap) tick();
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_reset();
      end else if (r < 4) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
      end
      pulse(16'($urandom), $urandom_range(2, 6));
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
